// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the EX-stage multiply/divide unit. The decoder and the
// unit both import this package so that the md_op encoding stays in one place.
//   md_op_e          : operation select carried on md_op (3 bits)
//   md_state_e       : FSM states of the unit
//   *_CYCLES_DEF     : default busy lengths for multiply and divide
//   is_md_start_op() : true for the multi-cycle ops launched by start
//   is_div_op()      : true for div/divu
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_start_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Connection between the EX-stage control/datapath and the multiply/divide unit.
//   md_op    : operation select (see md_op_e)
//   start    : decoder start for mult/multu/div/divu
//   req      : exception/interrupt request; suppresses HI/LO side effects
//   A, B     : forwarded rs / rt values
//   busy     : registered, high while an operation is in flight
//   md_stall : busy | (start & ~req), consumed by the hazard unit
//   HI, LO   : architectural HI/LO registers
// master = pipeline side, slave = mul_div_unit.
// -----------------------------------------------------------------------------
interface mul_div_unit_if;

    logic [2:0]  md_op;
    logic        start;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output md_op, start, req, A, B,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  md_op, start, req, A, B,
        output busy, md_stall, HI, LO
    );

endinterface

// File: rtl/mul_div_unit_md_compute.sv
// -----------------------------------------------------------------------------
// md_compute
// Purely combinational arithmetic for the multiply/divide unit.
//   md_op       : in  operation select
//   a, b        : in  operands (rs, rt)
//   result      : out {hi, lo} for the selected op
//   div_by_zero : out high for div/divu with b == 0 (result is then don't-care)
// Signed division is done on magnitudes and the signs are fixed afterwards, so
// the 0x80000000 / -1 corner simply wraps instead of overflowing a signed divide.
// -----------------------------------------------------------------------------
module md_compute
    import mul_div_unit_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        result      = '0;
        div_by_zero = 1'b0;
        neg_a       = (md_op == MD_DIV) && a[31];
        neg_b       = (md_op == MD_DIV) && b[31];
        mag_a       = neg_a ? (~a + 32'd1) : a;
        mag_b       = neg_b ? (~b + 32'd1) : b;
        // Divisor forced to 1 on zero so the divider never sees 0; the top
        // ignores the result in that case anyway.
        divisor     = (b == '0) ? 32'd1 : mag_b;
        quot_u      = mag_a / divisor;
        rem_u       = mag_a % divisor;

        case (md_op)
            MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: result = {32'd0, a} * {32'd0, b};
            MD_DIV, MD_DIVU: begin
                div_by_zero   = (b == '0);
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                result[31:0]  = (neg_a ^ neg_b) ? (~quot_u + 32'd1) : quot_u;
                result[63:32] = neg_a ? (~rem_u + 32'd1) : rem_u;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle multiply/divide unit of the EX stage; owns HI/LO.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : mul_div_unit_if.slave (md_op, start, req, A, B -> busy, md_stall, HI, LO)
// The result is computed in the start cycle and parked in temp_hi/temp_lo; it
// is committed to HI/LO when the cycle counter expires, so busy stays high for
// exactly MULT_CYCLES or DIV_CYCLES cycles after start.
// -----------------------------------------------------------------------------
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state;
    logic [CNT_W-1:0] count;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      temp_hi;
    logic [31:0]      temp_lo;
    logic [63:0]      result;
    logic             div_by_zero;
    logic             accept;

    md_compute u_compute (
        .md_op       (bus.md_op),
        .a           (bus.A),
        .b           (bus.B),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    assign accept       = (state == S_IDLE) && bus.start && !bus.req && is_md_start_op(bus.md_op);
    assign bus.busy     = busy_q;
    assign bus.md_stall = busy_q | (bus.start & ~bus.req);
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

    // NOTE: non-blocking assignments throughout, so every register samples the
    // pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            // NOTE: temp_hi/temp_lo are not reset: they are always loaded at
            // start before the commit that reads them.
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Divide by zero parks the current HI/LO, so the commit
                        // leaves them unchanged.
                        temp_hi <= div_by_zero ? hi_q : result[63:32];
                        temp_lo <= div_by_zero ? lo_q : result[31:0];
                        count   <= is_div_op(bus.md_op) ? DIV_LOAD : MULT_LOAD;
                        busy_q  <= 1'b1;
                        state   <= S_BUSY;
                    end else if (!bus.req && bus.md_op == MD_MTHI) begin
                        hi_q <= bus.A;
                    end else if (!bus.req && bus.md_op == MD_MTLO) begin
                        lo_q <= bus.A;
                    end
                end
                S_BUSY: begin
                    // start/mthi/mtlo/req are all ignored here; the op in flight
                    // belongs to an instruction that has already left EX.
                    if (count == CNT_ONE) begin
                        hi_q   <= temp_hi;
                        lo_q   <= temp_lo;
                        busy_q <= 1'b0;
                        count  <= '0;
                        state  <= S_IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    count  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit: the driver pushes the expected HI/LO and
// busy length of every launched op; a monitor pops and compares whenever busy
// falls. The reference model uses plain 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mul_div_unit_if bus ();

    mul_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: HI/LO outcome of a launched op from the current model state.
    function automatic exp_t model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t           e;
        longint         sa;
        longint         sb;
        longint         p;
        longint unsigned pu;
        e.hi     = model_hi;
        e.lo     = model_lo;
        e.cycles = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p    = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_MULTU: begin
                pu   = longint'(a) * longint'(b);
                e.hi = pu[63:32];
                e.lo = pu[31:0];
            end
            MD_DIV: if (b != 0) begin
                p    = sa / sb;
                e.lo = p[31:0];
                p    = sa % sb;
                e.hi = p[31:0];
            end
            MD_DIVU: if (b != 0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("busy_drops", 64'(bus.busy), 64'(0));
    endtask

    // Issue one operation for a single cycle, update the model, and wait for completion.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        logic launch;
        exp_t e;
        launch = is_md_start_op(op) && !rq;
        @(posedge clk); #1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = is_md_start_op(op);
        bus.req   = rq;
        #1;
        check("md_stall_issue", 64'(bus.md_stall), 64'(launch));
        if (launch) begin
            e = model_op(op, a, b);
            exp_q.push_back(e);
            model_hi = e.hi;
            model_lo = e.lo;
        end
        @(posedge clk); #1;
        bus.md_op = MD_NONE;
        bus.start = 1'b0;
        bus.req   = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        if (!rq && op == MD_MTHI) model_hi = a;
        if (!rq && op == MD_MTLO) model_lo = a;
        if (launch) begin
            wait_idle();
        end else begin
            check("busy_no_launch", 64'(bus.busy), 64'(0));
            check("hi_no_launch", 64'(bus.HI), 64'(model_hi));
            check("lo_no_launch", 64'(bus.LO), 64'(model_lo));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops and compares on every busy falling edge.
    initial begin
        logic prev_busy;
        int   busy_len;
        exp_t e;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                // An op in flight is aborted by reset and never commits.
                if (bus.busy === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
                prev_busy = 1'b0;
                busy_len  = 0;
            end else begin
                if (bus.busy) begin
                    busy_len++;
                    check("md_stall_while_busy", 64'(bus.md_stall), 64'(1));
                    check("no_start_while_busy", 64'(bus.start & ~bus.req), 64'(0));
                end
                if (prev_busy && !bus.busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_hi", 64'(bus.HI), 64'(e.hi));
                        check("sb_lo", 64'(bus.LO), 64'(e.lo));
                        check("sb_busy_len", 64'(busy_len), 64'(e.cycles));
                    end
                    busy_len = 0;
                end
                prev_busy = bus.busy;
            end
        end
    end

    // Driver
    initial begin
        exp_t e;
        bus.md_op = MD_NONE;
        bus.start = 1'b0;
        bus.req   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_hi", 64'(bus.HI), 64'(0));
        check("reset_lo", 64'(bus.LO), 64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_md_stall", 64'(bus.md_stall), 64'(0));

        // Directed cases with hand-computed results.
        do_op(MD_MULT, 32'hFFFF_FFFD, 32'd2, 1'b0);
        check("mult_neg3x2_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg3x2_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFA);

        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_hi", 64'(bus.HI), 64'h1);
        check("multu_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFE);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg7_2_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
        check("div_neg7_2_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);

        do_op(MD_MTHI, 32'h1234, 32'd0, 1'b0);
        check("mthi", 64'(bus.HI), 64'h1234);
        do_op(MD_MTLO, 32'h5678, 32'd0, 1'b0);
        check("mtlo", 64'(bus.LO), 64'h5678);
        do_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
        check("divu_by0_hi", 64'(bus.HI), 64'h1234);
        check("divu_by0_lo", 64'(bus.LO), 64'h5678);

        // Requests suppress launches and moves.
        do_op(MD_MULT, 32'd3, 32'd4, 1'b1);
        check("req_mult_hi", 64'(bus.HI), 64'h1234);
        do_op(MD_MTLO, 32'hDEAD, 32'd0, 1'b1);
        check("req_mtlo_lo", 64'(bus.LO), 64'h5678);

        // Reset in busy cycle 4 of a divu aborts it.
        @(posedge clk); #1;
        bus.md_op = MD_DIVU;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.start = 1'b1;
        e = model_op(MD_DIVU, 32'd100, 32'd7);
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.md_op = MD_NONE;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("busy_before_abort", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_hi", 64'(bus.HI), 64'(0));
        check("abort_lo", 64'(bus.LO), 64'(0));
        repeat (15) @(negedge clk);
        check("abort_no_late_hi", 64'(bus.HI), 64'(0));
        check("abort_no_late_lo", 64'(bus.LO), 64'(0));
        check("abort_no_late_busy", 64'(bus.busy), 64'(0));
        do_op(MD_MULTU, 32'd6, 32'd7, 1'b0);
        check("post_reset_multu_lo", 64'(bus.LO), 64'd42);
        check("post_reset_multu_hi", 64'(bus.HI), 64'd0);

        // Random operations against the model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        rq;
            op = 3'($urandom_range(1, 6));
            a  = pick_operand();
            b  = pick_operand();
            rq = ($urandom_range(0, 7) == 0);
            do_op(op, a, b, rq);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the P7 pipelined MIPS core.
- It is the responder to the decoder's `start` control: it accepts mult/multu/div/divu/mthi/mtlo operations and owns the HI/LO registers.
- It drives `busy` back to the hazard unit and supplies HI/LO to the EX result mux for mfhi/mflo.
- It obeys the exception request `req`, so that an excepting or interrupted instruction never commits to HI/LO.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- md_op, input, 3: operation select. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- start, input, 1: decoder start for mult/multu/div/divu, valid in EX.
- req, input, 1: exception/interrupt request this cycle; suppresses every HI/LO side effect of the EX instruction.
- A, input, 32: forwarded rs value.
- B, input, 32: forwarded rt value.
- busy, output, 1: registered; high while an operation is in flight.
- md_stall, output, 1: combinational busy | (start & ~req); the hazard unit uses it to stall mfhi/mflo/md ops in D.
- HI, output, 32: HI register.
- LO, output, 32: LO register.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, counter=0, state=IDLE.
  - Reset wins over every other input.
  - Reset mid-operation aborts the op; no HI/LO update occurs.
- States: IDLE, BUSY.
- IDLE, start=1, req=0, md_op in {1..4}:
  - Latch the result into temp_hi/temp_lo at the clock edge, computed from A/B of that cycle.
  - Set busy=1 and load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 1, at that edge: HI<=temp_hi, LO<=temp_lo, busy<=0, go to IDLE.
  - busy is high for exactly N consecutive cycles, starting the cycle after start.
  - The new HI/LO values are visible in the cycle busy first reads 0.
- start while BUSY: ignored, with no restart. The hazard unit guarantees this never happens, and the bench checks it as an assertion.
- mthi/mtlo (md_op 5/6):
  - Legal only in IDLE with req=0.
  - HI<=A or LO<=A at the edge, a one-cycle write with busy unaffected.
  - Ignored while BUSY.
- req=1: start, mthi and mtlo in that cycle are ignored. An op already in BUSY continues to completion, because its instruction has already retired past EX.
- Arithmetic:
  - mult: signed 32x32 into a 64-bit product; HI=product[63:32], LO=product[31:0].
  - multu: the same product, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B=0 on div/divu):
  - The unit still runs busy for DIV_CYCLES.
  - HI and LO are left unchanged at completion.
  - No exception is raised.
- md_op=0, or md_op in {1..4} without start: no effect.
- Outputs HI/LO change only at completion, on mthi/mtlo, or at reset.

Decomposition:
- Shared header: MD_OP encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and the default cycle counts. These live alongside the ALUOp constants so that the decoder and this unit agree.
- One sub-module, md_compute: purely combinational. It takes md_op, A and B, and outputs the 64-bit {hi,lo} result plus a div_by_zero flag.
- The top level holds the FSM, the counter and the HI/LO/temp registers.

Test Plan:
- mult with A=0xFFFFFFFD (-3), B=2, start=1:
  - busy high for cycles 1..5.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2:
  - After 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2:
  - busy for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/0, preceded by mthi 0x1234 and mtlo 0x5678:
  - busy for 10 cycles.
  - HI=0x1234, LO=0x5678 unchanged.
- mult 3*4 with start=1 and req=1 in the same cycle:
  - busy stays 0, md_stall=0, HI/LO unchanged.
  - mtlo with req=1: LO unchanged.
- divu 100/7 started, then reset asserted in busy cycle 4:
  - Next cycle busy=0, HI=0, LO=0.
  - No later update occurs.
  - A new multu 6*7 afterwards yields LO=42, HI=0.
